// File: rtl/fetch_request_unit.sv
// fetch_request_unit: instruction-fetch initiator for the program text memory bus.
//
// Holds the fetch PC and issues in-order pipelined reads under wait-request
// back-pressure. Every accepted request reserves a FIFO entry up front, so a
// response always has somewhere to land. Responses to requests issued before a
// redirect are counted as stale and discarded. Fetched words are presented to
// decode with their PCs through a valid/ready FIFO.
//
// Ports:
//   clock              system clock, all state updates on posedge
//   reset              asynchronous, active-high
//   i_redirect         flush and restart fetch at i_redirect_pc
//   i_redirect_pc      new fetch PC, bits [1:0] forced to 0
//   o_bus_read_enable  request strobe
//   o_bus_address      request address (current fetch PC)
//   i_bus_read_data    response data, sampled when i_bus_valid=1
//   i_bus_wait_req     bus refuses the request this cycle
//   i_bus_valid        one in-order response this cycle
//   o_inst_valid       head instruction available
//   o_inst             head instruction word
//   o_inst_pc          PC of the head instruction
//   i_inst_ready       decode consumes the head this cycle
//
// Configuration macro: FETCH_BYPASS_EN. When defined, a live response that
// arrives while the FIFO holds no filled entry is presented to decode in the
// same cycle; otherwise decode sees registered FIFO contents only.
module fetch_request_unit #(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [31:0] RESET_PC        = 32'h0040_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_bus_read_enable,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_read_data,
  input  logic        i_bus_wait_req,
  input  logic        i_bus_valid,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] r_issue, r_fill, r_head;
  logic [7:0]    r_in_flight, r_stale;
  logic [31:0]   r_pc;
  logic [31:0]   r_pc_mem   [FIFO_DEPTH];
  logic [31:0]   r_data_mem [FIFO_DEPTH];

  logic [PW-1:0] w_reserved;
  logic [8:0]    w_outstanding;
  logic          w_accept, w_live, w_empty, w_pop;

  // Entries are reserved at issue time, so issue-head bounds the FIFO usage.
  assign w_reserved    = r_issue - r_head;
  assign w_outstanding = {1'b0, r_in_flight} + {1'b0, r_stale};

  assign o_bus_read_enable = !reset && !i_redirect
                           && (w_reserved < PW'(FIFO_DEPTH))
                           && (w_outstanding < 9'(MAX_OUTSTANDING));
  assign o_bus_address     = r_pc;

  assign w_accept = o_bus_read_enable && !i_bus_wait_req;
  // A response is live only when no stale responses are still owed; one that
  // arrives during a redirect is folded into the stale accounting instead.
  assign w_live   = i_bus_valid && !i_redirect && (r_stale == 8'd0);
  assign w_empty  = (r_fill == r_head);

`ifdef FETCH_BYPASS_EN
  assign o_inst_valid = !w_empty || w_live;
  assign o_inst       = w_empty ? i_bus_read_data : r_data_mem[r_head[AW-1:0]];
`else
  assign o_inst_valid = !w_empty;
  assign o_inst       = r_data_mem[r_head[AW-1:0]];
`endif
  // With an empty FIFO head equals fill, so this is also the PC of the
  // entry a bypassed response belongs to.
  assign o_inst_pc = r_pc_mem[r_head[AW-1:0]];

  // A bypassed pop advances head together with fill, so the entry never
  // becomes visible as occupied.
  assign w_pop = o_inst_valid && i_inst_ready && !i_redirect;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_issue     <= '0;
      r_fill      <= '0;
      r_head      <= '0;
      r_in_flight <= 8'd0;
      r_stale     <= 8'd0;
      r_pc        <= RESET_PC;
    end else if (i_redirect) begin
      r_fill      <= r_issue;
      r_head      <= r_issue;
      r_pc        <= {i_redirect_pc[31:2], 2'b00};
      // Everything live becomes stale; a response this cycle is dropped.
      r_stale     <= r_stale + r_in_flight - {7'd0, i_bus_valid};
      r_in_flight <= 8'd0;
    end else begin
      if (w_accept) begin
        r_issue <= r_issue + 1'b1;
        r_pc    <= r_pc + 32'd4;
      end
      if (w_live) r_fill <= r_fill + 1'b1;
      if (w_pop) r_head <= r_head + 1'b1;
      r_in_flight <= r_in_flight + {7'd0, w_accept} - {7'd0, w_live};
      if (i_bus_valid && r_stale != 8'd0) r_stale <= r_stale - 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_accept) r_pc_mem[r_issue[AW-1:0]] <= r_pc;
    if (w_live) r_data_mem[r_fill[AW-1:0]] <= i_bus_read_data;
  end
endmodule

// File: tb/tb_fetch_request_unit.sv
// tb_fetch_request_unit: directed self-checking bench for fetch_request_unit
module tb_fetch_request_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        en;
  logic [31:0] addr;
  logic [31:0] rdata = 32'h0;
  logic        wait_req = 1'b0;
  logic        bvalid = 1'b0;
  logic        iv;
  logic [31:0] inst, inst_pc;
  logic        ready = 1'b0;
  logic        en2, iv2;
  logic [31:0] addr2, inst2, pc2;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int lat = 5;
  int first_v = -1;
  int acc_cnt = 0;

  typedef struct { int due; logic [31:0] a; } req_t;
  req_t        q[$];
  logic [31:0] log_pc[$];
  logic [31:0] log_inst[$];

`ifdef FETCH_BYPASS_EN
  localparam int FIRST_V = 6;
  localparam int RX_B    = 11;
`else
  localparam int FIRST_V = 7;
  localparam int RX_B    = 10;
`endif

  always #5 clock = ~clock;

  fetch_request_unit #(.FIFO_DEPTH(8), .MAX_OUTSTANDING(6), .RESET_PC(32'h0040_0000)) dut (
    .clock(clock), .reset(reset), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_bus_read_enable(en), .o_bus_address(addr), .i_bus_read_data(rdata),
    .i_bus_wait_req(wait_req), .i_bus_valid(bvalid), .o_inst_valid(iv),
    .o_inst(inst), .o_inst_pc(inst_pc), .i_inst_ready(ready)
  );

  fetch_request_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clock(clock), .reset(reset), .i_redirect(1'b0), .i_redirect_pc(32'h0),
    .o_bus_read_enable(en2), .o_bus_address(addr2), .i_bus_read_data(32'h0),
    .i_bus_wait_req(1'b0), .i_bus_valid(1'b0), .o_inst_valid(iv2),
    .o_inst(inst2), .o_inst_pc(pc2), .i_inst_ready(1'b0)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  function automatic logic [31:0] lp(input int i);
    return (log_pc.size() > i) ? log_pc[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] li(input int i);
    return (log_inst.size() > i) ? log_inst[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Ends one cycle: logs acceptances/pops, crosses the edge, then plays the
  // bus response (fixed latency, in order) for the new cycle.
  task automatic tick();
    if (en && !wait_req) begin
      q.push_back('{due: cyc + lat, a: addr});
      acc_cnt++;
    end
    if (iv && ready && !redirect) begin
      log_pc.push_back(inst_pc);
      log_inst.push_back(inst);
    end
    if (iv && first_v < 0) first_v = cyc;
    @(posedge clock);
    #1;
    cyc++;
    if (q.size() > 0 && q[0].due == cyc) begin
      bvalid = 1'b1;
      rdata  = mem_word(q[0].a);
      void'(q.pop_front());
    end else begin
      bvalid = 1'b0;
      rdata  = 32'h0;
    end
  endtask

  initial begin
    #1 reset = 1'b1;
    #2;
    chk("rst_en", {31'b0, en}, 32'd0);
    chk("rst_addr", addr, 32'h0040_0000);
    chk("rst_iv", {31'b0, iv}, 32'd0);
    chk("rst_addr_wrap_pc", addr2, 32'hFFFF_FFFC);
    @(posedge clock);
    #1;
    reset = 1'b0;
    ready = 1'b1;
    cyc = 1;
    for (int c = 1; c <= 16; c++) begin
      #1;
      if (c == 1) begin
        chk("first_req_en", {31'b0, en}, 32'd1);
        chk("first_req_en_wrap", {31'b0, en2}, 32'd1);
      end
      if (c <= 4) chk($sformatf("stream_addr_c%0d", c), addr, 32'h0040_0000 + 32'(4 * (c - 1)));
      if (c == 2) chk("wrap_second_addr", addr2, 32'h0000_0000);
      tick();
    end
    chk("first_valid_cycle", 32'(first_v), 32'(FIRST_V));
    chk("stream_rx_count", 32'(log_pc.size()), 32'(RX_B));
    chk("stream_pc0", lp(0), 32'h0040_0000);
    chk("stream_inst0", li(0), 32'hDEED_0000);
    chk("stream_pc9", lp(9), 32'h0040_0024);
    chk("stream_inst9", li(9), 32'hDEED_0024);

    reset = 1'b1;
    q.delete();
    bvalid = 1'b0;
    rdata = 32'h0;
    #1;
    chk("midrst_en", {31'b0, en}, 32'd0);
    chk("midrst_addr", addr, 32'h0040_0000);
    chk("midrst_iv", {31'b0, iv}, 32'd0);
    tick();
    reset = 1'b0;
    cyc = 1;
    log_pc.delete();
    log_inst.delete();
    for (int c = 1; c <= 18; c++) begin
      wait_req = (c >= 3 && c <= 5);
      #1;
      if (c >= 3 && c <= 6) chk($sformatf("hold_addr_c%0d", c), addr, 32'h0040_0008);
      if (c >= 3 && c <= 5) chk($sformatf("hold_en_c%0d", c), {31'b0, en}, 32'd1);
      tick();
    end
    chk("hold_pc1", lp(1), 32'h0040_0004);
    chk("hold_pc2", lp(2), 32'h0040_0008);
    chk("hold_inst2", li(2), 32'hDEED_0008);
    chk("hold_pc3", lp(3), 32'h0040_000C);

    wait_req = 1'b1;
    repeat (7) begin #1; tick(); end
    log_pc.delete();
    log_inst.delete();
    wait_req = 1'b0;
    repeat (3) begin #1; chk("pre_redir_en", {31'b0, en}, 32'd1); tick(); end
    redirect = 1'b1;
    redirect_pc = 32'h0040_0103;
    #1;
    chk("redir_en", {31'b0, en}, 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    chk("post_redir_en", {31'b0, en}, 32'd1);
    chk("post_redir_addr", addr, 32'h0040_0100);
    tick();
    repeat (14) begin #1; tick(); end
    chk("redir_pc0", lp(0), 32'h0040_0100);
    chk("redir_inst0", li(0), 32'hDEED_0100);
    chk("redir_pc1", lp(1), 32'h0040_0104);

    wait_req = 1'b1;
    repeat (7) begin #1; tick(); end
    log_pc.delete();
    log_inst.delete();
    wait_req = 1'b0;
    repeat (2) begin #1; tick(); end
    wait_req = 1'b1;
    repeat (3) begin #1; tick(); end
    redirect = 1'b1;
    redirect_pc = 32'h0050_0000;
    wait_req = 1'b0;
    #1;
    chk("redir_valid_iv", {31'b0, iv}, 32'd0);
    tick();
    redirect = 1'b0;
    repeat (15) begin #1; tick(); end
    chk("stale1_pc0", lp(0), 32'h0050_0000);
    chk("stale1_inst0", li(0), 32'hDEFD_0000);
    chk("stale1_pc1", lp(1), 32'h0050_0004);
    chk("stale1_inst1", li(1), 32'hDEFD_0004);

    ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h0060_0000;
    acc_cnt = 0;
    #1;
    tick();
    redirect = 1'b0;
    repeat (25) begin #1; tick(); end
    #1;
    chk("full_accept_count", 32'(acc_cnt), 32'd8);
    chk("full_en", {31'b0, en}, 32'd0);
    chk("full_iv", {31'b0, iv}, 32'd1);
    chk("full_head_pc", inst_pc, 32'h0060_0000);
    chk("full_head_inst", inst, 32'hDECD_0000);
    ready = 1'b1;
    #1;
    chk("pop_cycle_en", {31'b0, en}, 32'd0);
    tick();
    ready = 1'b0;
    #1;
    chk("after_pop_en", {31'b0, en}, 32'd1);
    chk("after_pop_addr", addr, 32'h0060_0020);
    chk("after_pop_head_pc", inst_pc, 32'h0060_0004);
    tick();
    #1;
    chk("refull_en", {31'b0, en}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
